// File: rtl/branch_resolve.sv
// branch_resolve: registered RV32I conditional-branch resolution stage.
// Evaluates the branch condition from the raw operands plus the upstream
// unsigned-compare result, forms the next PC and a mispredict flag, and holds
// the result in a one-entry output register with a valid/ready handshake.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken
// counters (taken_cnt / nottaken_cnt ports).
module branch_resolve #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] ltu_i,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            capture;
  logic            eq_c, ltu_c, lt_c, taken_c, illegal_c, mispred_c;
  logic [XLEN-1:0] target_c;
  logic            taken_q, mispred_q, illegal_q;
  logic [XLEN-1:0] target_q;

  // Only bit 0 of the comparator result carries information.
  logic unused_ltu_hi;
  assign unused_ltu_hi = ^ltu_i[XLEN-1:1];

  // Condition evaluation, target and mispredict from the current inputs
  always_comb begin
    eq_c      = (op_a == op_b);
    ltu_c     = ltu_i[0];
    // Differing signs decide signed order directly; same signs reuse ltu.
    lt_c      = (op_a[XLEN-1] ^ op_b[XLEN-1]) ? op_a[XLEN-1] : ltu_c;
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (funct3)
      3'b000:  taken_c = eq_c;
      3'b001:  taken_c = !eq_c;
      3'b100:  taken_c = lt_c;
      3'b101:  taken_c = !lt_c;
      3'b110:  taken_c = ltu_c;
      3'b111:  taken_c = !ltu_c;
      default: illegal_c = 1'b1;
    endcase
    mispred_c = taken_c ^ pred_taken;
    target_c  = taken_c ? (pc + imm) : (pc + XLEN'(4));
  end

  // Handshake control: next state and capture strobe, flush has priority
  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == EMPTY) || out_ready;
    capture  = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else if (in_valid && in_ready) begin
      capture = 1'b1;
      state_d = FULL;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Result register: loads only on capture, otherwise holds stable
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q   <= 1'b0;
      mispred_q <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
    end else if (capture) begin
      taken_q   <= taken_c;
      mispred_q <= mispred_c;
      illegal_q <= illegal_c;
      target_q  <= target_c;
    end
  end

  assign out_valid      = (state_q == FULL);
  assign out_taken      = taken_q;
  assign out_mispredict = mispred_q;
  assign out_illegal    = illegal_q;
  assign out_target     = target_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, nottaken_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Statistics: count legal captured branches by outcome, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else if (capture && !illegal_c) begin
      if (taken_c) taken_cnt_q    <= sat_inc(taken_cnt_q);
      else         nottaken_cnt_q <= sat_inc(nottaken_cnt_q);
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases plus randomized
// traffic compared against a behavioural model of the stage.
module tb_branch_resolve;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] op_a, op_b, ltu_i, pc, imm;
  logic [2:0]      funct3;
  logic            pred_taken, flush;
  logic            out_valid, out_ready;
  logic            out_taken, out_mispredict, out_illegal;
  logic [XLEN-1:0] out_target;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt, nottaken_cnt;
`endif

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .ltu_i(ltu_i), .funct3(funct3),
    .pc(pc), .imm(imm), .pred_taken(pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .out_target(out_target)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model state (what the output register should hold)
  logic        m_valid, m_taken, m_mis, m_ill;
  logic [31:0] m_tgt;
  int          m_tc, m_nc;
  int          cnt_max = (1 << CNT_W) - 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Branch semantics straight from the ISA definition
  function automatic void ref_resolve(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f, input logic [31:0] p,
                                      input logic [31:0] im, input logic pr,
                                      output logic tk, output logic ill,
                                      output logic mis, output logic [31:0] tgt);
    tk  = 1'b0;
    ill = 1'b0;
    case (f)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = ($signed(a) <  $signed(b));
      3'd5: tk = ($signed(a) >= $signed(b));
      3'd6: tk = (a <  b);
      3'd7: tk = (a >= b);
      default: ill = 1'b1;
    endcase
    mis = tk ^ pr;
    tgt = tk ? (p + im) : (p + 32'd4);
  endfunction

  task automatic model_edge();
    logic tk, ill, mis;
    logic [31:0] tgt;
    if (rst) begin
      m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0; m_tgt = 0; m_tc = 0; m_nc = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      ref_resolve(op_a, op_b, funct3, pc, imm, pred_taken, tk, ill, mis, tgt);
      m_valid = 1; m_taken = tk; m_ill = ill; m_mis = mis; m_tgt = tgt;
      if (!ill) begin
        if (tk) m_tc = (m_tc < cnt_max) ? m_tc + 1 : m_tc;
        else    m_nc = (m_nc < cnt_max) ? m_nc + 1 : m_nc;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid",      {31'd0, out_valid},      {31'd0, m_valid});
    check_eq("out_taken",      {31'd0, out_taken},      {31'd0, m_taken});
    check_eq("out_mispredict", {31'd0, out_mispredict}, {31'd0, m_mis});
    check_eq("out_illegal",    {31'd0, out_illegal},    {31'd0, m_ill});
    check_eq("out_target",     out_target,              m_tgt);
`ifdef BRANCH_STATS_EN
    check_eq("taken_cnt",      {30'd0, taken_cnt},      32'(m_tc));
    check_eq("nottaken_cnt",   {30'd0, nottaken_cnt},   32'(m_nc));
`endif
  endtask

  // One clock: drive inputs at negedge, check in_ready, clock, check outputs
  task automatic cyc(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] f, input logic [31:0] p, input logic [31:0] im,
                     input logic pr, input logic fl, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = v; op_a = a; op_b = b; funct3 = f; pc = p; imm = im;
    pred_taken = pr; flush = fl; out_ready = ordy;
    ltu_i = ($urandom() & 32'hFFFF_FFFE) | {31'd0, (a < b)};
    #1;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || ordy)});
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  logic [31:0] held_tgt;

  initial begin
    rst = 1; in_valid = 0; op_a = 0; op_b = 0; ltu_i = 0; funct3 = 0;
    pc = 0; imm = 0; pred_taken = 0; flush = 0; out_ready = 0;
    m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0; m_tgt = 0; m_tc = 0; m_nc = 0;

    // Reset then idle
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 5, 0, 32'h40, 8, 1, 0, 1);
    idle(0);
    check_eq("rst_valid",  {31'd0, out_valid}, 32'd0);
    check_eq("rst_ready",  {31'd0, in_ready},  32'd1);
    check_eq("rst_target", out_target, 32'd0);
    check_eq("rst_flags",  {29'd0, out_taken, out_mispredict, out_illegal}, 32'd0);

    // BLTU 1 < 0xFFFFFFFF taken, predicted not taken
    cyc(0, 1, 32'd1, 32'hFFFF_FFFF, 3'b110, 32'h100, 32'h20, 0, 0, 1);
    check_eq("bltu_taken",  {31'd0, out_taken},      32'd1);
    check_eq("bltu_target", out_target,              32'h120);
    check_eq("bltu_mis",    {31'd0, out_mispredict}, 32'd1);
    // BLT: 1 < -1 false
    cyc(0, 1, 32'd1, 32'hFFFF_FFFF, 3'b100, 32'h100, 32'h20, 0, 0, 1);
    check_eq("blt_taken",  {31'd0, out_taken}, 32'd0);
    check_eq("blt_target", out_target,         32'h104);
    // BGE most-negative vs 5: not taken
    cyc(0, 1, 32'h8000_0000, 32'd5, 3'b101, 32'h200, 32'h40, 1, 0, 1);
    check_eq("bge_taken",  {31'd0, out_taken},      32'd0);
    check_eq("bge_mis",    {31'd0, out_mispredict}, 32'd1);
    check_eq("bge_target", out_target,              32'h204);
    // BEQ with target wrap
    cyc(0, 1, 32'h1234, 32'h1234, 3'b000, 32'hFFFF_FFFC, 32'd8, 1, 0, 1);
    check_eq("beq_wrap", out_target, 32'h0000_0004);
    check_eq("beq_mis",  {31'd0, out_mispredict}, 32'd0);

    // Backpressure: hold three cycles with a new branch waiting
    held_tgt = out_target;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'd7, 32'd9, 3'b001, 32'h300, 32'h10, 0, 0, 0);
      check_eq("bp_in_ready", {31'd0, in_ready},  32'd0);
      check_eq("bp_hold_tgt", out_target,         held_tgt);
      check_eq("bp_valid",    {31'd0, out_valid}, 32'd1);
    end
    cyc(0, 1, 32'd7, 32'd9, 3'b001, 32'h300, 32'h10, 0, 0, 1);
    check_eq("bp_capture", out_target, 32'h310);

    // Flush while FULL with an incoming branch
    cyc(0, 1, 32'd3, 32'd3, 3'b000, 32'h400, 32'h80, 0, 1, 1);
    check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_tgt",   out_target,         32'h310);
    // Illegal funct3
    cyc(0, 1, 32'd3, 32'd3, 3'b010, 32'h500, 32'h80, 1, 0, 1);
    check_eq("ill_flag",  {31'd0, out_illegal},    32'd1);
    check_eq("ill_taken", {31'd0, out_taken},      32'd0);
    check_eq("ill_mis",   {31'd0, out_mispredict}, 32'd1);
    check_eq("ill_tgt",   out_target,              32'h504);
    idle(1);

`ifdef BRANCH_STATS_EN
    // Saturation of the 2-bit taken counter
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'd8, 32'd8, 3'b000, 32'h600, 32'h4, 1, 0, 1);
    check_eq("sat_taken",    {30'd0, taken_cnt},    32'd3);
    check_eq("sat_nottaken", {30'd0, nottaken_cnt}, 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, b;
      a = $urandom();
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ 32'h8000_0000;
        2: b = {a[31], 31'($urandom())};
        default: b = $urandom();
      endcase
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), a, b,
          3'($urandom_range(0, 7)), $urandom(), $urandom(), 1'($urandom()),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Registered branch-resolution stage directly downstream of the ALU's unsigned comparator. Consumes the comparator's SLTU result together with the raw operands, evaluates the RV32I conditional-branch condition selected by `funct3`, computes the next-PC target, and flags a misprediction. The result is presented through a one-entry output register with a valid/ready handshake to the fetch redirect logic.

## Interface
- `XLEN`, 32, operand/PC width
- `CNT_W`, 16, width of statistics counters (used only with `BRANCH_STATS_EN`)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  branch operands/controls valid
- `in_ready`  out  1  stage can accept this cycle
- `op_a`, `op_b`  in  XLEN  rs1/rs2 values
- `ltu_i`  in  XLEN  unsigned-compare result (1 when `op_a < op_b` unsigned, else 0); only bit 0 used
- `funct3`  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- `pc`, `imm`  in  XLEN  branch PC and sign-extended B-immediate
- `pred_taken`  in  1  fetch-stage prediction
- `flush`  in  1  discard held and incoming branch
- `out_valid`  out  1  resolved result valid
- `out_ready`  in  1  consumer accepts result
- `out_taken`, `out_mispredict`, `out_illegal`  out  1  resolution flags
- `out_target`  out  XLEN  next PC actually taken
- `taken_cnt`, `nottaken_cnt`  out  CNT_W  present only with `BRANCH_STATS_EN`

## Operation
- Conditions, combinational on inputs: `eq = (op_a == op_b)`; `ltu = ltu_i[0]`; `lt = (op_a[XLEN-1] ^ op_b[XLEN-1]) ? op_a[XLEN-1] : ltu`.
- taken: BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu.
- `funct3` 010/011: illegal; taken=0, `out_illegal`=1, `out_mispredict` = `pred_taken`.
- `out_target` = taken ? `pc + imm` : `pc + 4`, modulo 2^XLEN (wraps, no overflow flag).
- `out_mispredict` = taken XOR `pred_taken`.
- Two-state control: EMPTY (`out_valid`=0), FULL (`out_valid`=1).
  - EMPTY: `in_valid` & !`flush` -> capture, go FULL.
  - FULL: `out_ready` & `in_valid` & !`flush` -> capture new, stay FULL; `out_ready` & !`in_valid` -> EMPTY; !`out_ready` -> hold all outputs stable.
- `in_ready` = !`out_valid` | `out_ready` (combinational pass-through of `out_ready`; no skid entry).
- `flush` has priority: next state EMPTY, no capture that cycle regardless of `in_valid`/`out_ready`; counters not updated.

## Timing
- Latency: 1 cycle, accept edge to `out_valid`=1. Throughput 1 branch/cycle with `out_ready` held high.
- Reset (`rst`=1 at edge): `out_valid`=0, `out_taken`=0, `out_mispredict`=0, `out_illegal`=0, `out_target`=0, counters=0; `in_ready`=1 after reset. Reset mid-transfer drops the held branch; `rst` overrides `flush`.
- Outputs must not change while `out_valid`=1 and `out_ready`=0.

## Configuration
- `BRANCH_STATS_EN` defined: `taken_cnt`/`nottaken_cnt` ports and registers exist; each captured legal branch increments the matching counter by 1, saturating at 2^CNT_W-1; illegal captures increment neither; cleared by `rst` only.
- Undefined: ports and registers absent; behaviour otherwise identical.

## Test plan
- Reset then idle: `out_valid`=0, `in_ready`=1, `out_target`=0 -> all flags 0.
- BLTU `op_a`=1, `op_b`=0xFFFFFFFF, `ltu_i`=1, `pc`=0x100, `imm`=0x20, `pred_taken`=0 -> next cycle `out_taken`=1, `out_target`=0x120, `out_mispredict`=1; same operands BLT -> taken=0, target 0x104.
- BGE `op_a`=0x80000000, `op_b`=5 -> not taken; BEQ equal operands with `pc`=0xFFFFFFFC, `imm`=8 -> target 0x00000004 (wrap).
- Backpressure: result held with `out_ready`=0 for 3 cycles while `in_valid`=1 -> `in_ready`=0, outputs stable; `out_ready`=1 -> new branch captured same edge.
- `flush` asserted with `in_valid`=1 and FULL -> next cycle `out_valid`=0, no counter change; `funct3`=010 -> `out_illegal`=1, `out_taken`=0.
- With `BRANCH_STATS_EN`, `CNT_W`=2: 5 taken branches -> `taken_cnt`=3 (saturated), `nottaken_cnt`=0.
